// File: rtl/obj_pkg.sv
// Sprite bitmaps, sizes, channel count and magnification encoding.
package obj_pkg;
  localparam int NUM_OBJ  = 4;
  localparam int ObjSizeX = 8;
  localparam int ObjSizeY = 8;

  typedef enum logic [1:0] {
    SCALE_1X = 2'd0,
    SCALE_2X = 2'd1,
    SCALE_4X = 2'd2,
    SCALE_8X = 2'd3
  } scale_e;

  // Rows packed MSB-first: the top byte is row 7, bit x is column x.
  localparam logic [63:0] BmpSolid = {64{1'b1}};
  localparam logic [63:0] BmpCheck = {4{8'hAA, 8'h55}};

  localparam logic [NUM_OBJ-1:0][ObjSizeY-1:0][ObjSizeX-1:0] Obj =
    {BmpCheck, BmpCheck, BmpSolid, BmpSolid};

  typedef struct packed {
    logic       active;
    logic [3:0] border;
  } s1_t;

  function automatic logic [1:0] scale_shift(input logic [1:0] s);
    logic [1:0] sh;
    sh = 2'd0;
    unique case (s)
      SCALE_1X: sh = 2'd0;
      SCALE_2X: sh = 2'd1;
      SCALE_4X: sh = 2'd2;
      SCALE_8X: sh = 2'd3;
      default:  sh = 2'd0;
    endcase
    return sh;
  endfunction
endpackage

// File: rtl/vga_hd_pkg.sv
// Active-area geometry of the 1280x720 video timing.
package vga_hd_pkg;
  localparam int ActivePels  = 1280;
  localparam int ActiveLines = 720;
endpackage

// File: rtl/sprite_hit_unit.sv
// Stage 1 of one sprite channel: bounds test plus bitmap lookup,
// registered as a single opaque flag.
module sprite_hit_unit
  import obj_pkg::*;
#(
  parameter int IDX     = 0,
  parameter int COORD_W = 12
) (
  input  logic               vid_clk,
  input  logic               vid_reset,
  input  logic [COORD_W-1:0] i_h,
  input  logic [COORD_W-1:0] i_v,
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  input  logic               i_en,
  input  logic [1:0]         i_scale,
  output logic               o_opaque
);
  localparam int XB = $clog2(ObjSizeX);
  localparam int YB = $clog2(ObjSizeY);
  localparam int BI = IDX % NUM_OBJ;
  localparam logic [COORD_W:0] LimX = (COORD_W+1)'(ObjSizeX);
  localparam logic [COORD_W:0] LimY = (COORD_W+1)'(ObjSizeY);

  logic [COORD_W:0] w_rel_x;
  logic [COORD_W:0] w_rel_y;
  logic [COORD_W:0] w_sx;
  logic [COORD_W:0] w_sy;
  logic [1:0]       w_sh;
  logic             w_inside;
  logic             w_bit;
  logic             r_opaque;

  // One extra bit keeps the difference signed, so no wrap-around hits.
  assign w_rel_x = {1'b0, i_h} - {1'b0, i_x};
  assign w_rel_y = {1'b0, i_v} - {1'b0, i_y};
  assign w_sh    = scale_shift(i_scale);
  assign w_sx    = w_rel_x >> w_sh;
  assign w_sy    = w_rel_y >> w_sh;

  assign w_inside = !w_rel_x[COORD_W] && !w_rel_y[COORD_W]
                 && (w_sx < LimX) && (w_sy < LimY);
  assign w_bit    = Obj[BI][w_sy[YB-1:0]][w_sx[XB-1:0]];

  always_ff @(posedge vid_clk) begin
    if (vid_reset) r_opaque <= 1'b0;
    else           r_opaque <= i_en & w_inside & w_bit;
  end

  assign o_opaque = r_opaque;
endmodule

// File: rtl/sprite_compositor.sv
// Two-stage sprite/border compositor with per-frame collision and
// border-overlap reporting.
module sprite_compositor #(
  parameter int NUM_OBJ  = obj_pkg::NUM_OBJ,
  parameter int COORD_W  = 12,
  parameter int COLOR_W  = 24,
  parameter int H_ACTIVE = vga_hd_pkg::ActivePels,
  parameter int V_ACTIVE = vga_hd_pkg::ActiveLines
) (
  input  logic                              vid_clk,
  input  logic                              vid_reset,
  input  logic                              active,
  input  logic                              frame_start,
  input  logic [COORD_W-1:0]                active_h,
  input  logic [COORD_W-1:0]                active_v,
  input  logic [3:0][7:0]                   frame_widths,
  input  logic [3:0][COLOR_W-1:0]           frame_color,
  input  logic [NUM_OBJ-1:0][COORD_W-1:0]   obj_x,
  input  logic [NUM_OBJ-1:0][COORD_W-1:0]   obj_y,
  input  logic [NUM_OBJ-1:0]                obj_en,
  input  logic [NUM_OBJ-1:0][COLOR_W-1:0]   obj_color,
  input  logic [NUM_OBJ-1:0][1:0]           obj_scale,
  input  logic [NUM_OBJ-1:0][1:0]           obj_prio,
  output logic [COLOR_W:0]                  vid_action_layer,
  output logic [NUM_OBJ-1:0]                obj_collision,
  output logic [NUM_OBJ-1:0]                obj_border_hit,
  output logic                              collision_valid
);
  localparam logic [COORD_W:0] HA = (COORD_W+1)'(H_ACTIVE);
  localparam logic [COORD_W:0] VA = (COORD_W+1)'(V_ACTIVE);

  logic [3:0][COORD_W:0] w_w;
  logic [3:0]            w_border;
  obj_pkg::s1_t          w_s1;
  obj_pkg::s1_t          r_s1;
  logic [NUM_OBJ-1:0]    w_opq;
  logic                  w_found;
  logic [1:0]            w_best;
  logic [COLOR_W-1:0]    w_win;
  logic [COLOR_W:0]      w_layer;
  logic                  w_multi;
  logic [NUM_OBJ-1:0]    w_coll;
  logic [NUM_OBJ-1:0]    w_bhit;

  logic [COLOR_W:0]      r_layer;
  logic [NUM_OBJ-1:0]    r_acc_c;
  logic [NUM_OBJ-1:0]    r_acc_b;
  logic [NUM_OBJ-1:0]    r_coll;
  logic [NUM_OBJ-1:0]    r_bhit;
  logic                  r_valid;
  logic                  r_armed;

  for (genvar k = 0; k < 4; k++) begin : g_w
    assign w_w[k] = {{(COORD_W-7){1'b0}}, frame_widths[k]};
  end

  assign w_border[0] = {1'b0, active_h} < w_w[0];
  assign w_border[1] = ({1'b0, active_h} + w_w[1]) >= HA;
  assign w_border[2] = {1'b0, active_v} < w_w[2];
  assign w_border[3] = ({1'b0, active_v} + w_w[3]) >= VA;

  assign w_s1.active = active;
  assign w_s1.border = w_border;

  for (genvar g = 0; g < NUM_OBJ; g++) begin : g_obj
    sprite_hit_unit #(
      .IDX     (g),
      .COORD_W (COORD_W)
    ) u_hit (
      .vid_clk   (vid_clk),
      .vid_reset (vid_reset),
      .i_h       (active_h),
      .i_v       (active_v),
      .i_x       (obj_x[g]),
      .i_y       (obj_y[g]),
      .i_en      (obj_en[g]),
      .i_scale   (obj_scale[g]),
      .o_opaque  (w_opq[g])
    );
  end

  // Ascending scan with >= lets the highest index win a prio tie.
  always_comb begin
    w_found = 1'b0;
    w_best  = 2'd0;
    w_win   = '0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      if (w_opq[i] && (!w_found || obj_prio[i] >= w_best)) begin
        w_found = 1'b1;
        w_best  = obj_prio[i];
        w_win   = obj_color[i];
      end
    end
  end

  always_comb begin
    w_layer = '0;
    if (r_s1.active) begin
      priority case (1'b1)
        r_s1.border[0]: w_layer = {1'b1, frame_color[0]};
        r_s1.border[1]: w_layer = {1'b1, frame_color[1]};
        r_s1.border[2]: w_layer = {1'b1, frame_color[2]};
        r_s1.border[3]: w_layer = {1'b1, frame_color[3]};
        w_found:        w_layer = {1'b1, w_win};
        default:        w_layer = '0;
      endcase
    end
  end

  // Two or more opaque bits set iff clearing the lowest one leaves some.
  assign w_multi = |(w_opq & (w_opq - NUM_OBJ'(1)));
  assign w_coll  = w_opq & {NUM_OBJ{r_s1.active & w_multi}};
  assign w_bhit  = w_opq & {NUM_OBJ{r_s1.active & (|r_s1.border)}};

  always_ff @(posedge vid_clk) begin
    if (vid_reset) begin
      r_s1    <= '0;
      r_layer <= '0;
      r_acc_c <= '0;
      r_acc_b <= '0;
      r_coll  <= '0;
      r_bhit  <= '0;
      r_valid <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_s1    <= w_s1;
      r_layer <= w_layer;
      r_valid <= frame_start;
      if (frame_start) begin
        r_coll  <= r_armed ? r_acc_c : '0;
        r_bhit  <= r_armed ? r_acc_b : '0;
        r_acc_c <= w_coll;
        r_acc_b <= w_bhit;
        r_armed <= 1'b1;
      end else begin
        r_acc_c <= r_acc_c | w_coll;
        r_acc_b <= r_acc_b | w_bhit;
      end
    end
  end

  assign vid_action_layer = r_layer;
  assign obj_collision    = r_coll;
  assign obj_border_hit   = r_bhit;
  assign collision_valid  = r_valid;
endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: pixels, priority, scaling,
// borders, frame reporting and reset behaviour.
module tb_sprite_compositor;
  localparam int N = 4;

  logic                  vid_clk;
  logic                  vid_reset;
  logic                  active;
  logic                  frame_start;
  logic [11:0]           active_h;
  logic [11:0]           active_v;
  logic [3:0][7:0]       frame_widths;
  logic [3:0][23:0]      frame_color;
  logic [N-1:0][11:0]    obj_x;
  logic [N-1:0][11:0]    obj_y;
  logic [N-1:0]          obj_en;
  logic [N-1:0][23:0]    obj_color;
  logic [N-1:0][1:0]     obj_scale;
  logic [N-1:0][1:0]     obj_prio;
  logic [24:0]           vid_action_layer;
  logic [N-1:0]          obj_collision;
  logic [N-1:0]          obj_border_hit;
  logic                  collision_valid;

  int checks;
  int failures;

  sprite_compositor dut (
    .vid_clk          (vid_clk),
    .vid_reset        (vid_reset),
    .active           (active),
    .frame_start      (frame_start),
    .active_h         (active_h),
    .active_v         (active_v),
    .frame_widths     (frame_widths),
    .frame_color      (frame_color),
    .obj_x            (obj_x),
    .obj_y            (obj_y),
    .obj_en           (obj_en),
    .obj_color        (obj_color),
    .obj_scale        (obj_scale),
    .obj_prio         (obj_prio),
    .vid_action_layer (vid_action_layer),
    .obj_collision    (obj_collision),
    .obj_border_hit   (obj_border_hit),
    .collision_valid  (collision_valid)
  );

  initial vid_clk = 1'b0;
  always #5 vid_clk = ~vid_clk;

  task automatic step(input int n);
    repeat (n) @(posedge vid_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pix(input logic [11:0] h, input logic [11:0] v,
                     input logic act);
    active_h = h;
    active_v = v;
    active   = act;
    step(2);
  endtask

  task automatic fs(input logic [N-1:0] ec, input logic [N-1:0] eb,
                    input string tag);
    active = 1'b0;
    step(2);
    frame_start = 1'b1;
    step(1);
    frame_start = 1'b0;
    chk({tag, "_coll"}, 32'(obj_collision), 32'(ec));
    chk({tag, "_bhit"}, 32'(obj_border_hit), 32'(eb));
    chk({tag, "_valid1"}, 32'(collision_valid), 32'd1);
    step(1);
    chk({tag, "_valid0"}, 32'(collision_valid), 32'd0);
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    vid_reset    = 1'b1;
    active       = 1'b1;
    frame_start  = 1'b0;
    active_h     = '0;
    active_v     = '0;
    frame_widths = '0;
    frame_color[0] = 24'h0000AA;
    frame_color[1] = 24'h00BB00;
    frame_color[2] = 24'hCC0000;
    frame_color[3] = 24'hDDDDDD;
    obj_x     = '0;
    obj_y     = '0;
    obj_en    = '0;
    obj_color = '0;
    obj_scale = '0;
    obj_prio  = '0;

    step(3);
    chk("rst_layer", 32'(vid_action_layer), 32'd0);
    chk("rst_coll", 32'(obj_collision), 32'd0);
    chk("rst_bhit", 32'(obj_border_hit), 32'd0);
    chk("rst_valid", 32'(collision_valid), 32'd0);
    vid_reset = 1'b0;
    active    = 1'b0;
    step(1);

    // single sprite at (100,50)
    obj_x[0] = 12'd100;
    obj_y[0] = 12'd50;
    obj_en[0] = 1'b1;
    obj_color[0] = 24'hFF0000;
    pix(12'd103, 12'd52, 1'b1);
    chk("s0_in", 32'(vid_action_layer), 32'h1FF0000);
    pix(12'd99, 12'd52, 1'b1);
    chk("s0_left", 32'(vid_action_layer), 32'd0);
    pix(12'd107, 12'd57, 1'b1);
    chk("s0_last", 32'(vid_action_layer), 32'h1FF0000);
    pix(12'd108, 12'd52, 1'b1);
    chk("s0_right", 32'(vid_action_layer), 32'd0);
    pix(12'd103, 12'd52, 1'b0);
    chk("s0_blank", 32'(vid_action_layer), 32'd0);
    fs(4'b0000, 4'b0000, "fs1");

    // overlap and priority
    obj_x[0] = 12'd196;  obj_y[0] = 12'd196;  obj_prio[0] = 2'd1;
    obj_x[1] = 12'd198;  obj_y[1] = 12'd198;  obj_prio[1] = 2'd3;
    obj_en[1] = 1'b1;
    obj_color[1] = 24'h00FF00;
    pix(12'd200, 12'd200, 1'b1);
    chk("prio_hi1", 32'(vid_action_layer), 32'h100FF00);
    obj_prio[0] = 2'd3;
    pix(12'd200, 12'd200, 1'b1);
    chk("prio_tie", 32'(vid_action_layer), 32'h100FF00);
    obj_prio[1] = 2'd1;
    pix(12'd200, 12'd200, 1'b1);
    chk("prio_hi0", 32'(vid_action_layer), 32'h1FF0000);
    obj_x[2] = 12'd300;  obj_y[2] = 12'd300;
    obj_en[2] = 1'b1;
    obj_color[2] = 24'h0000FF;
    pix(12'd300, 12'd300, 1'b1);
    chk("chk_on", 32'(vid_action_layer), 32'h10000FF);
    pix(12'd301, 12'd300, 1'b1);
    chk("chk_off", 32'(vid_action_layer), 32'd0);
    pix(12'd300, 12'd301, 1'b1);
    chk("chk_odd", 32'(vid_action_layer), 32'd0);
    fs(4'b0011, 4'b0000, "fs2");

    // magnification and far-right sprite
    obj_en = 4'b0001;
    obj_x[0] = 12'd0;  obj_y[0] = 12'd0;
    obj_scale[0] = 2'd2;
    pix(12'd31, 12'd31, 1'b1);
    chk("sc4_in", 32'(vid_action_layer), 32'h1FF0000);
    pix(12'd32, 12'd0, 1'b1);
    chk("sc4_out", 32'(vid_action_layer), 32'd0);
    obj_x[0] = 12'd4090;
    pix(12'd5, 12'd0, 1'b1);
    chk("nowrap", 32'(vid_action_layer), 32'd0);
    fs(4'b0000, 4'b0000, "fs3");

    // borders
    frame_widths = {8'd2, 8'd2, 8'd2, 8'd2};
    obj_x[0] = 12'd0;
    obj_scale[0] = 2'd0;
    pix(12'd0, 12'd0, 1'b1);
    chk("bd_left", 32'(vid_action_layer), 32'h10000AA);
    pix(12'd1279, 12'd0, 1'b1);
    chk("bd_right", 32'(vid_action_layer), 32'h100BB00);
    pix(12'd640, 12'd1, 1'b1);
    chk("bd_top", 32'(vid_action_layer), 32'h1CC0000);
    pix(12'd640, 12'd719, 1'b1);
    chk("bd_bot", 32'(vid_action_layer), 32'h1DDDDDD);
    pix(12'd1277, 12'd360, 1'b1);
    chk("bd_inner", 32'(vid_action_layer), 32'd0);
    pix(12'd1278, 12'd360, 1'b1);
    chk("bd_edge", 32'(vid_action_layer), 32'h100BB00);
    pix(12'd0, 12'd0, 1'b0);
    chk("bd_blank", 32'(vid_action_layer), 32'd0);
    fs(4'b0000, 4'b0001, "fs4");

    // reset mid-frame after a collision
    frame_widths = '0;
    obj_en = 4'b0011;
    obj_x[0] = 12'd200;  obj_y[0] = 12'd200;
    obj_x[1] = 12'd198;  obj_y[1] = 12'd198;
    obj_prio[0] = 2'd1;
    obj_prio[1] = 2'd3;
    pix(12'd200, 12'd200, 1'b1);
    chk("pre_rst", 32'(vid_action_layer), 32'h100FF00);
    vid_reset = 1'b1;
    step(2);
    chk("mrst_layer", 32'(vid_action_layer), 32'd0);
    chk("mrst_bhit", 32'(obj_border_hit), 32'd0);
    vid_reset = 1'b0;
    fs(4'b0000, 4'b0000, "fs5");
    step(1);
    chk("fs5_valid_once", 32'(collision_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
